// File: rtl/fwd_hazard_scoreboard.sv
// fwd_hazard_scoreboard: operand forwarding select, load-use and scoreboard
// hazard detection, and a single ID-stage stall. Forwarding and hazard terms
// are combinational. The long-latency register scoreboard is registered.

// Per-operand lane: forwarding select and this operand's hazard terms.
module fwd_operand_lane #(
    parameter int NUM_STAGES = 2,
    parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                        src_valid,
    input  logic [4:0]                  src_addr,
    input  logic [NUM_STAGES-1:0]       stg_we,
    input  logic [NUM_STAGES-1:0][4:0]  stg_rd,
    input  logic [NUM_STAGES-1:0]       stg_rdy,
    input  logic [31:0]                 busy,
    output logic [SEL_W-1:0]            fwd_sel,
    output logic                        load_use,
    output logic                        raw
);
    logic win_rdy;

    // Walk from the oldest stage to the youngest so the youngest match wins.
    // The winner's ready flag alone decides load-use: an older ready copy is
    // stale relative to the younger in-flight load.
    always_comb begin
        fwd_sel = '0;
        win_rdy = 1'b1;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (stg_we[j] && (stg_rd[j] != 5'd0) && (stg_rd[j] == src_addr)) begin
                fwd_sel = SEL_W'(j + 1);
                win_rdy = stg_rdy[j];
            end
        end
    end

    // Hazards count only when the operand is really read. busy[0] is always 0,
    // so x0 never raises RAW.
    always_comb begin
        load_use = src_valid && (fwd_sel != '0) && !win_rdy;
        raw      = src_valid && busy[src_addr];
    end
endmodule

// Top: lanes for each source operand plus the long-latency scoreboard.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC      = 2,
    parameter int NUM_STAGES   = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int SEL_W        = $clog2(NUM_STAGES + 1),
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*5-1:0]      src_addr,
    input  logic [4:0]                id_rd,
    input  logic                      id_we,
    input  logic [NUM_STAGES-1:0]     stg_we,
    input  logic [NUM_STAGES*5-1:0]   stg_rd,
    input  logic [NUM_STAGES-1:0]     stg_rdy,
    input  logic                      ll_issue,
    input  logic                      ll_wb_valid,
    input  logic [4:0]                ll_wb_rd,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic                      ll_accept,
    output logic [CNT_W-1:0]          inflight,
    output logic                      sb_err,
    output logic [31:0]               stall_cnt
);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_INFLIGHT);

    logic [NUM_STAGES-1:0][4:0] stg_rd_a;
    logic [NUM_SRC-1:0]         lu_vec;
    logic [NUM_SRC-1:0]         raw_vec;

    logic [31:0]      busy_q, busy_nxt;
    logic [CNT_W-1:0] inflight_q, inflight_nxt;
    logic             sb_err_q;
    logic [31:0]      stall_cnt_q;

    logic waw, cap_full, wb_hit, wb_bad;

    assign stg_rd_a = stg_rd;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
        fwd_operand_lane #(
            .NUM_STAGES(NUM_STAGES),
            .SEL_W     (SEL_W)
        ) u_lane (
            .src_valid(src_valid[k]),
            .src_addr (src_addr[5*k +: 5]),
            .stg_we   (stg_we),
            .stg_rd   (stg_rd_a),
            .stg_rdy  (stg_rdy),
            .busy     (busy_q),
            .fwd_sel  (fwd_sel[SEL_W*k +: SEL_W]),
            .load_use (lu_vec[k]),
            .raw      (raw_vec[k])
        );
    end

    // Stall/accept. Only registered busy is used, so a writeback in the same
    // cycle does not release a dependent instruction until the next cycle.
    always_comb begin
        waw       = id_we && busy_q[id_rd];
        cap_full  = ll_issue && (inflight_q == CAP);
        stall     = (|lu_vec) || (|raw_vec) || waw || cap_full;
        ll_accept = ll_issue && !stall;
        wb_hit    = ll_wb_valid && busy_q[ll_wb_rd];
        wb_bad    = ll_wb_valid && !busy_q[ll_wb_rd];
    end

    // Next scoreboard state. A same-cycle accept and writeback always target
    // different registers (WAW blocks the same one), so set and clear commute.
    always_comb begin
        busy_nxt = busy_q;
        if (wb_hit)
            busy_nxt[ll_wb_rd] = 1'b0;
        if (ll_accept && (id_rd != 5'd0))
            busy_nxt[id_rd] = 1'b1;
        busy_nxt[0] = 1'b0;

        inflight_nxt = inflight_q;
        if (ll_accept && !wb_hit && (inflight_q != CAP))
            inflight_nxt = inflight_q + CNT_W'(1);
        else if (wb_hit && !ll_accept && (inflight_q != '0))
            inflight_nxt = inflight_q - CNT_W'(1);
    end

    // Scoreboard, sticky error and saturating stall counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            inflight_q  <= '0;
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q     <= busy_nxt;
            inflight_q <= inflight_nxt;
            if (wb_bad)
                sb_err_q <= 1'b1;
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign inflight  = inflight_q;
    assign sb_err    = sb_err_q;
    assign stall_cnt = stall_cnt_q;
endmodule
